ram_delay_mc: RTL and testbench
===============================

# ram_delay_mc

Multi-channel, RAM-backed, runtime-programmable delay line and comb section for the sample-rate DSP path. It replaces the fixed-length register shift chain with one circular buffer per channel, addressed by per-channel write pointers. It adds a valid-qualified output, a selectable delay from 1 to L, feed-forward and feedback comb modes with a signed gain, and saturation. It sits between the input sample stream and downstream filter stages, and carries C time-interleaved channels on one bus.

## Interface
- `W`, 12: sample width, signed two's complement.
- `L`, 256: maximum delay per channel, in samples; power of two.
- `C`, 2: number of interleaved channels; power of two, ≥1.
- `GW`, 16: gain width, signed Q1.(GW-1).
- `clk`  in  1: sole clock.
- `reset`  in  1: reset is synchronous and active-high.
- `ena`  in  1: clock enable; when low, all state (including the clear sweep and the pipeline) holds.
- `din`  in  W: input sample.
- `ch_in`  in  max(1,$clog2(C)): channel index of `din`.
- `valid_in`  in  1: `din`/`ch_in` qualifier; ignored while `ready`=0.
- `delay`  in  $clog2(L)+1: delay D in samples of the same channel; sampled with each valid sample.
- `gain`  in  GW: comb gain g; sampled with each valid sample.
- `mode`  in  2: 00 bypass, 01 pure delay, 10 feedback comb, 11 feed-forward comb.
- `ready`  out  1: low during the post-reset clear sweep.
- `dout`  out  W: output sample.
- `ch_out`  out  same width as `ch_in`: channel index of `dout`.
- `valid_out`  out  1: `dout`/`ch_out` qualifier.

## Operation
- **FSM states.**
  - CLEAR: walks addresses 0..C·L-1, writing 0; `ready`=0.
  - RUN: `ready`=1.
  - Transitions: reset → CLEAR; CLEAR → RUN after the last address is written. There are no other transitions.
- **Memory.** C·L words, address = {ch, wr_ptr[ch]}. Per-channel `wr_ptr` starts at 0 and increments modulo L after each accepted sample of that channel.
- **Read address.** (wr_ptr[ch] − D) mod L.
  - D=0 is treated as 1; D>L is clamped to L.
  - D=L reads the word being overwritten (read-before-write).
- **Arithmetic.** Let r = delayed word.
  - p = (g·r) >>> (GW-1), arithmetic shift, truncation.
  - s = sat_W(x ± p); sums are formed at W+2 bits, then saturated to [−2^(W−1), 2^(W−1)−1].
- **Modes.**
  - Bypass: dout = x; stores x.
  - Delay: dout = r; stores x.
  - Feedback comb: dout = s = sat(x + p); stores s.
  - Feed-forward comb: dout = sat(x + p); stores x.
- **Hazard.** In-flight writes (stages 1–2) matching the stage-0 read address are forwarded. Back-to-back same-channel samples with D=1 in feedback mode must therefore be exact.
- **Quasi-static `mode`.** A change applies from the next sample. Memory is not cleared.
- **Reset mid-operation.** Pipeline valids drop, pointers reset to 0, CLEAR restarts. No pre-reset sample ever appears at `dout`.

## Timing
- **Reset values.** `dout`=0, `ch_out`=0, `valid_out`=0, `ready`=0.
- **Clear sweep.** `ready` rises C·L enabled cycles after reset deasserts.
- **Latency.** Fixed at 2 enabled cycles from `valid_in` to `valid_out` in all modes. Pipeline: stage 0 = RAM read + capture; stage 1 = RAM data + multiply; stage 2 = add, saturate, write-back, output register.
- **Throughput.** One sample per cycle, any channel order.
- **`valid_out` shape.** A one-cycle pulse per accepted sample. `dout` holds its value between pulses.
- **Samples during CLEAR.** `valid_in` during CLEAR is dropped: no pointer update, no output.
- **`ena` low.** Freezes everything; `valid_out` holds its level.

## Structure
- Package `ram_delay_pkg`: `mode_t` enum (BYPASS, DELAY, FB_COMB, FF_COMB), FSM state enum, and the `sat` function parametrised by width.
- Sub-module `delay_ram`: simple dual-port synchronous RAM (one write port, one read port), 1-cycle read, read-before-write on address collision.
- Top level holds the FSM, pointer array, forwarding, and datapath.

## Test plan
All scenarios use W=12, L=8, C=2, GW=16.
- **Reset/clear.** Reset for 1 cycle → `ready`=0 for 16 cycles, then 1. `valid_out`=0 and `dout`=0 throughout.
- **Pure delay.** D=3, ch0 impulse 100 then zeros → `dout`=100 on the 4th ch0 output. Every `valid_out` comes 2 cycles after its `valid_in`. D=0 behaves as D=1; D=8 returns the sample from 8 writes earlier.
- **Feedback comb.** g=0x4000 (0.5), D=1, back-to-back ch0 impulse 1000 → 1000, 500, 250, 125, 62, 31.
- **Saturation.** Feedback mode, g=0x7FFF, D=1, constant 2047 → `dout` climbs to and stays at 2047. Constant −2048 → stays at −2048; no wrap.
- **Channel isolation.** Alternate ch0/ch1, D=2. ch0 carries 1, 2, 3…; ch1 carries −1, −2, −3… → each channel's output is its own input delayed by 2, with `ch_out` matching. No crosstalk.
- **Mid-run reset.** Assert reset during streaming → `valid_out`=0 the next cycle, the 16-cycle clear repeats, and the first post-reset delayed outputs are 0.

Source files
------------

// File: rtl/ram_delay_pkg.sv
// Shared types and helpers for the RAM-backed multi-channel delay/comb block.
package ram_delay_pkg;

  typedef enum logic [1:0] {
    BYPASS  = 2'b00,
    DELAY   = 2'b01,
    FB_COMB = 2'b10,
    FF_COMB = 2'b11
  } mode_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module delay_ram #(
  parameter int W     = 12,
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_delay_mc.sv
// Multi-channel programmable delay line / comb filter built on one circular
// buffer per channel, with a fixed two-cycle pipeline and write forwarding.
module ram_delay_mc
  import ram_delay_pkg::*;
#(
  parameter int W  = 12,
  parameter int L  = 256,
  parameter int C  = 2,
  parameter int GW = 16,
  localparam int CW = (C > 1) ? $clog2(C) : 1,
  localparam int DW = $clog2(L) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  input  logic [W-1:0]  din,
  input  logic [CW-1:0] ch_in,
  input  logic          valid_in,
  input  logic [DW-1:0] delay,
  input  logic [GW-1:0] gain,
  input  logic [1:0]    mode,
  output logic          ready,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] ch_out,
  output logic          valid_out
);

  localparam int AW  = $clog2(L);
  localparam int RAW = $clog2(C * L);
  localparam int PW  = W + 1;
  localparam int SW  = W + 2;

  state_t         state;
  logic [RAW-1:0] clr_addr;
  logic [AW-1:0]  wr_ptr [C];

  logic           accept;
  logic [AW-1:0]  d_low;
  logic [RAW-1:0] rd_addr;
  logic [RAW-1:0] wr_addr0;
  logic           fwd_hit;
  logic [W-1:0]   fwd_data;

  logic                 s1_valid;
  logic signed [W-1:0]  s1_x;
  logic [CW-1:0]        s1_ch;
  logic signed [GW-1:0] s1_gain;
  mode_t                s1_mode;
  logic [RAW-1:0]       s1_waddr;
  logic                 s1_fwd;
  logic [W-1:0]         s1_fwd_data;

  logic [W-1:0]            rd_data;
  logic signed [W-1:0]     r1;
  logic signed [GW+W-1:0]  prod;
  logic signed [W:0]       p;
  logic signed [W+1:0]     sum;
  logic signed [W-1:0]     sat_s;
  logic [W-1:0]            out1;
  logic [W-1:0]            store1;

  logic [RAW-1:0] wb_addr;
  logic [W-1:0]   wb_data;
  logic           ram_we;
  logic [RAW-1:0] ram_waddr;
  logic [W-1:0]   ram_wdata;

  assign accept = ena & ready & valid_in;

  // Clear sweep walks every word once after reset, then the block runs forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else if (ena) begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + RAW'(1);
          if (clr_addr == '1) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // D=0 behaves as 1; D>=L wraps to offset 0, i.e. the word about to be overwritten.
  always_comb begin
    d_low = delay[AW-1:0];
    if (delay == '0) d_low = AW'(1);
    else if (delay >= DW'(L)) d_low = '0;
  end

  assign rd_addr  = RAW'({ch_in, wr_ptr[ch_in] - d_low});
  assign wr_addr0 = RAW'({ch_in, wr_ptr[ch_in]});

  // The newer in-flight write (stage 1) wins over the one committing this cycle.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (s1_valid && (s1_waddr == rd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = store1;
    end else if (valid_out && (wb_addr == rd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_x        <= '0;
      s1_ch       <= '0;
      s1_gain     <= '0;
      s1_mode     <= BYPASS;
      s1_waddr    <= '0;
      s1_fwd      <= 1'b0;
      s1_fwd_data <= '0;
      for (int i = 0; i < C; i++) wr_ptr[i] <= '0;
    end else if (ena) begin
      s1_valid <= accept;
      if (accept) begin
        s1_x          <= din;
        s1_ch         <= ch_in;
        s1_gain       <= gain;
        s1_mode       <= mode_t'(mode);
        s1_waddr      <= wr_addr0;
        s1_fwd        <= fwd_hit;
        s1_fwd_data   <= fwd_data;
        wr_ptr[ch_in] <= wr_ptr[ch_in] + AW'(1);
      end
    end
  end

  delay_ram #(.W(W), .DEPTH(C * L)) u_ram (
    .clk   (clk),
    .en    (ena),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    ram_we    = valid_out;
    ram_waddr = wb_addr;
    ram_wdata = wb_data;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end
  end

  always_comb begin
    r1     = s1_fwd ? s1_fwd_data : rd_data;
    prod   = s1_gain * r1;
    p      = PW'(prod >>> (GW - 1));
    sum    = SW'(s1_x) + SW'(p);
    sat_s  = W'(sat(32'(sum), W));
    out1   = s1_x;
    store1 = s1_x;
    case (s1_mode)
      BYPASS:  out1 = s1_x;
      DELAY:   out1 = r1;
      FB_COMB: begin
        out1   = sat_s;
        store1 = sat_s;
      end
      FF_COMB: out1 = sat_s;
      default: out1 = s1_x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      dout      <= '0;
      ch_out    <= '0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else if (ena) begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        dout    <= out1;
        ch_out  <= s1_ch;
        wb_addr <= s1_waddr;
        wb_data <= store1;
      end
    end
  end

endmodule

// File: tb/tb_ram_delay_mc.sv
// Directed self-checking bench for ram_delay_mc with W=12, L=8, C=2, GW=16.
module tb_ram_delay_mc;
  import ram_delay_pkg::*;

  localparam int W  = 12;
  localparam int L  = 8;
  localparam int C  = 2;
  localparam int GW = 16;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ena = 1'b1;
  logic [W-1:0]  din = '0;
  logic [0:0]    ch_in = '0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] delay = '0;
  logic [GW-1:0] gain = '0;
  logic [1:0]    mode = '0;
  logic          ready;
  logic [W-1:0]  dout;
  logic [0:0]    ch_out;
  logic          valid_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:0] ch;
    int         x;
    int         d;
    int         g;
    logic [1:0] m;
    int         e;
  } step_t;

  step_t stream[$];

  ram_delay_mc #(.W(W), .L(L), .C(C), .GW(GW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .din       (din),
    .ch_in     (ch_in),
    .valid_in  (valid_in),
    .delay     (delay),
    .gain      (gain),
    .mode      (mode),
    .ready     (ready),
    .dout      (dout),
    .ch_out    (ch_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [0:0] ch, input int x,
                               input int d, input int g, input logic [1:0] m);
    valid_in = v;
    ch_in    = ch;
    din      = W'(x);
    delay    = DW'(d);
    gain     = GW'(g);
    mode     = m;
    tick();
  endtask

  task automatic addStep(input logic [0:0] ch, input int x, input int d, input int g,
                         input logic [1:0] m, input int e);
    step_t s;
    s.ch = ch;
    s.x  = x;
    s.d  = d;
    s.g  = g;
    s.m  = m;
    s.e  = e;
    stream.push_back(s);
  endtask

  // Back-to-back samples; each output is checked exactly two cycles after its input.
  task automatic runStream(input string tag);
    int n;
    n = stream.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) applyStimulus(1'b1, stream[i].ch, stream[i].x, stream[i].d, stream[i].g, stream[i].m);
      else applyStimulus(1'b0, 1'b0, 0, 1, 0, 2'b01);
      if (i == 0) begin
        checkOutput($sformatf("%s lead valid", tag), int'(valid_out), 0);
      end else begin
        checkOutput($sformatf("%s[%0d] valid", tag, i - 1), int'(valid_out), 1);
        checkOutput($sformatf("%s[%0d] dout", tag, i - 1), int'($signed(dout)), stream[i-1].e);
        checkOutput($sformatf("%s[%0d] ch", tag, i - 1), int'(ch_out), int'(stream[i-1].ch));
      end
    end
    tick();
    checkOutput($sformatf("%s tail valid", tag), int'(valid_out), 0);
    checkOutput($sformatf("%s tail hold", tag), int'($signed(dout)), stream[n-1].e);
    stream.delete();
  endtask

  task automatic resetDut(input string tag);
    valid_in = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (16) tick();
    checkOutput($sformatf("%s ready", tag), int'(ready), 1);
  endtask

  initial begin
    // Reset values and clear sweep, with samples offered during CLEAR that must be dropped
    tick();
    checkOutput("reset ready", int'(ready), 0);
    checkOutput("reset valid", int'(valid_out), 0);
    checkOutput("reset dout", int'(dout), 0);
    checkOutput("reset ch", int'(ch_out), 0);
    reset    = 1'b0;
    valid_in = 1'b1;
    din      = W'(777);
    delay    = DW'(1);
    mode     = 2'b01;
    for (int i = 0; i < 15; i++) begin
      tick();
      checkOutput("clear ready", int'(ready), 0);
      checkOutput("clear valid", int'(valid_out), 0);
      checkOutput("clear dout", int'(dout), 0);
    end
    tick();
    checkOutput("ready rise", int'(ready), 1);
    checkOutput("ready rise valid", int'(valid_out), 0);
    valid_in = 1'b0;
    tick();
    checkOutput("dropped clear sample", int'(valid_out), 0);

    // Pure delay D=3 impulse
    addStep(0, 100, 3, 0, 2'b01, 0);
    addStep(0, 0, 3, 0, 2'b01, 0);
    addStep(0, 0, 3, 0, 2'b01, 0);
    addStep(0, 0, 3, 0, 2'b01, 100);
    addStep(0, 0, 3, 0, 2'b01, 0);
    runStream("delay3");

    // D=0 acts as D=1
    addStep(0, 5, 0, 0, 2'b01, 0);
    addStep(0, 6, 0, 0, 2'b01, 5);
    addStep(0, 7, 0, 0, 2'b01, 6);
    runStream("delay0");

    // D=8 returns the word written 8 samples earlier; D=12 clamps to 8
    addStep(0, 10, 8, 0, 2'b01, 100);
    addStep(0, 11, 8, 0, 2'b01, 0);
    addStep(0, 12, 8, 0, 2'b01, 0);
    addStep(0, 13, 8, 0, 2'b01, 0);
    addStep(0, 14, 8, 0, 2'b01, 0);
    addStep(0, 15, 8, 0, 2'b01, 5);
    addStep(0, 16, 8, 0, 2'b01, 6);
    addStep(0, 17, 8, 0, 2'b01, 7);
    addStep(0, 20, 12, 0, 2'b01, 10);
    addStep(0, 21, 12, 0, 2'b01, 11);
    runStream("delay8");

    // Feedback comb g=0.5, D=1, back-to-back
    resetDut("fb reset");
    addStep(0, 1000, 1, 16384, 2'b10, 1000);
    addStep(0, 0, 1, 16384, 2'b10, 500);
    addStep(0, 0, 1, 16384, 2'b10, 250);
    addStep(0, 0, 1, 16384, 2'b10, 125);
    addStep(0, 0, 1, 16384, 2'b10, 62);
    addStep(0, 0, 1, 16384, 2'b10, 31);
    runStream("fbcomb");

    // Saturation at both rails
    addStep(0, 2047, 1, 32767, 2'b10, 2047);
    addStep(0, 2047, 1, 32767, 2'b10, 2047);
    addStep(0, 2047, 1, 32767, 2'b10, 2047);
    addStep(0, 2047, 1, 32767, 2'b10, 2047);
    runStream("satpos");
    addStep(0, -2048, 1, 32767, 2'b10, -2);
    addStep(0, -2048, 1, 32767, 2'b10, -2048);
    addStep(0, -2048, 1, 32767, 2'b10, -2048);
    addStep(0, -2048, 1, 32767, 2'b10, -2048);
    runStream("satneg");

    // Feed-forward comb g=-0.5 on ch1, then bypass and a mode switch
    addStep(1, 400, 2, 'hC000, 2'b11, 400);
    addStep(1, 100, 2, 'hC000, 2'b11, 100);
    addStep(1, 0, 2, 'hC000, 2'b11, -200);
    addStep(1, 0, 2, 'hC000, 2'b11, -50);
    addStep(1, 7, 1, 0, 2'b00, 7);
    addStep(1, -9, 1, 0, 2'b00, -9);
    addStep(1, 0, 1, 0, 2'b01, -9);
    runStream("ffcomb");

    // Channel isolation with alternating channels, D=2
    resetDut("iso reset");
    addStep(0, 1, 2, 0, 2'b01, 0);
    addStep(1, -1, 2, 0, 2'b01, 0);
    addStep(0, 2, 2, 0, 2'b01, 0);
    addStep(1, -2, 2, 0, 2'b01, 0);
    addStep(0, 3, 2, 0, 2'b01, 1);
    addStep(1, -3, 2, 0, 2'b01, -1);
    addStep(0, 4, 2, 0, 2'b01, 2);
    addStep(1, -4, 2, 0, 2'b01, -2);
    runStream("iso");

    // Reset while streaming
    applyStimulus(1'b1, 1'b0, 50, 1, 0, 2'b01);
    applyStimulus(1'b1, 1'b0, 60, 1, 0, 2'b01);
    checkOutput("prereset valid", int'(valid_out), 1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 70, 1, 0, 2'b01);
    checkOutput("midreset valid", int'(valid_out), 0);
    checkOutput("midreset ready", int'(ready), 0);
    checkOutput("midreset dout", int'(dout), 0);
    reset    = 1'b0;
    valid_in = 1'b0;
    repeat (15) tick();
    checkOutput("reclear ready low", int'(ready), 0);
    tick();
    checkOutput("reclear ready", int'(ready), 1);
    addStep(0, 5, 1, 0, 2'b01, 0);
    addStep(0, 6, 1, 0, 2'b01, 5);
    addStep(0, 9, 8, 0, 2'b01, 0);
    runStream("postreset");

    // Clock enable freezes the pipeline and holds valid_out
    applyStimulus(1'b1, 1'b0, 33, 1, 0, 2'b01);
    applyStimulus(1'b1, 1'b0, 44, 1, 0, 2'b01);
    checkOutput("ena pre valid", int'(valid_out), 1);
    checkOutput("ena pre dout", int'($signed(dout)), 9);
    ena      = 1'b0;
    valid_in = 1'b0;
    tick();
    tick();
    checkOutput("ena hold valid", int'(valid_out), 1);
    checkOutput("ena hold dout", int'($signed(dout)), 9);
    ena = 1'b1;
    tick();
    checkOutput("ena resume valid", int'(valid_out), 1);
    checkOutput("ena resume dout", int'($signed(dout)), 33);
    tick();
    checkOutput("ena drain valid", int'(valid_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
